regfile_tile_ctrl: RTL
======================

Name: regfile_tile_ctrl

Overview:
Load sequencer for the vector register file. It accepts a row stream from the DMA over a valid/ready handshake and turns each accepted row into a write (WE, addr, dataIn) to the register file. After all NoOfElem rows are written it presents the tile to the consumer, driving the register file's transpose select from a per-tile flag. It sits between the DMA read channel and the register file, and owns the file's write port and transpose control.

Parameters:
wordSize, 32, bits per word
words, 16, words per row
NoOfElem, 16, rows per tile (power of 2, ≥2)

Ports:
clk  in  1  clock
RESET  in  1  synchronous active-high reset, sampled on posedge clk
start  in  1  begin a tile load; honoured in IDLE only
start_transpose  in  1  transpose flag, latched with start
abort  in  1  cancel the current tile
s_valid  in  1  DMA row valid
s_ready  out  1  controller ready for a row
s_data  in  words*wordSize  row payload
s_last  in  1  DMA marks the final row
rf_we  out  1  register file write enable
rf_addr  out  $clog2(NoOfElem)  register file row address
rf_dataIn  out  words*wordSize  register file write data
rf_transpose  out  1  register file transpose select
tile_valid  out  1  tile complete and readable
tile_ack  in  1  consumer releases the tile
busy  out  1  state != IDLE
err_short  out  1  one-cycle pulse: s_last arrived before the final row

Behaviour:
- Reset: clk and RESET are the codebase names; RESET is synchronous and active-high, fixed. On RESET, state=IDLE and row_cnt=0. All outputs are 0, including rf_dataIn. RESET overrides every other input, including in mid-load; a write already registered is dropped.
- States: IDLE, LOAD, COMMIT, FULL.
- IDLE:
  - s_ready=0.
  - start=1 → LOAD; row_cnt=0; tflag ← start_transpose.
- LOAD:
  - s_ready = !abort.
  - Handshake = s_valid & s_ready.
  - On a handshake in cycle N: in cycle N+1, rf_we=1, rf_addr=row_cnt (pre-increment), rf_dataIn=s_data from cycle N. All three are registered; row_cnt increments.
  - No handshake → rf_we=0 in the next cycle; rf_addr and rf_dataIn hold.
  - A handshake with row_cnt==NoOfElem-1 → COMMIT.
  - A handshake with s_last=1 and row_cnt<NoOfElem-1 → COMMIT, and err_short=1 in cycle N+1. Unwritten rows keep their prior contents.
  - s_last on the final row, or no s_last at all: no error.
- COMMIT:
  - Lasts one cycle; the final rf_we is asserted here.
  - Then → FULL, so tile_valid rises 2 cycles after the last handshake.
- FULL:
  - tile_valid=1 and rf_transpose=tflag; s_ready=0.
  - tile_ack=1 → IDLE; tile_valid and rf_transpose drop the next cycle.
- rf_transpose is 0 outside FULL.
- abort in LOAD, COMMIT or FULL → IDLE next cycle.
  - An rf_we already registered for that cycle still fires.
  - No further writes; row_cnt is cleared.
  - abort in IDLE has no effect.
- Simultaneous events:
  - start outside IDLE is ignored, not queued.
  - tile_ack outside FULL is ignored.
  - abort has priority over a handshake: s_ready is 0 in that cycle.
  - start together with abort in IDLE → LOAD (abort is a no-op in IDLE).
- Width: row_cnt is $clog2(NoOfElem) bits and never wraps, because the final handshake exits LOAD.

Optional Feature:
REGFILE_CTRL_PERF_EN
- Defined: adds output tile_cnt [15:0] and output stall_cnt [15:0].
  - tile_cnt increments on each tile_ack accepted in FULL; wraps at 16 bits.
  - stall_cnt increments each LOAD cycle with s_valid=0; saturates at 16'hFFFF.
  - Both cleared by RESET only.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- start, start_transpose=0; 16 back-to-back rows with s_data=row index, s_last on row 15 → rf_we high 16 consecutive cycles, rf_addr 0..15, rf_dataIn=index; tile_valid 2 cycles after the last handshake; rf_transpose=0; err_short=0.
- start_transpose=1; s_valid toggles 1/0 → rf_we only after handshakes with rf_addr strictly sequential; rf_transpose=1 only while tile_valid=1; tile_ack → tile_valid=0 and rf_transpose=0 next cycle.
- s_last on row 5 → 6 writes (addr 0..5); err_short pulses one cycle together with the addr-5 write; tile_valid follows 1 cycle later.
- In FULL, drive s_valid=1 and start=1, then tile_ack → s_ready stays 0; start is ignored; after IDLE, a fresh start writes again from addr 0.
- abort in the handshake cycle of row 8 → s_ready=0 in that cycle; no write for row 8; IDLE next cycle; busy=0; the next tile starts at addr 0.
- RESET=1 during LOAD at row 10 → next cycle all outputs 0 and state IDLE; no rf_we for the row in flight.

Source files
------------

// File: rtl/regfile_tile_ctrl.sv
// regfile_tile_ctrl: load sequencer for the vector register file.
// Accepts DMA rows over valid/ready and turns each accepted row into a
// registered register-file write. It then presents the finished tile to the
// consumer with a per-tile transpose select.
// Optional build macro REGFILE_CTRL_PERF_EN adds the tile_cnt and stall_cnt
// performance counters.
module regfile_tile_ctrl #(
  parameter int wordSize  = 32,
  parameter int words     = 16,
  parameter int NoOfElem  = 16,
  localparam int AW       = $clog2(NoOfElem),
  localparam int DW       = words * wordSize
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          start,
  input  logic          start_transpose,
  input  logic          abort,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_dataIn,
  output logic          rf_transpose,
  output logic          tile_valid,
  input  logic          tile_ack,
  output logic          busy,
`ifdef REGFILE_CTRL_PERF_EN
  output logic [15:0]   tile_cnt,
  output logic [15:0]   stall_cnt,
`endif
  output logic          err_short
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, FULL} state_e;

  localparam logic [AW-1:0] LAST_ROW = AW'(NoOfElem - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] row_cnt_q, row_cnt_d;
  logic          tflag_q, tflag_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_addr_q, rf_addr_d;
  logic [DW-1:0] rf_data_q, rf_data_d;
  logic          err_short_q, err_short_d;
  logic          handshake;

  // Abort takes priority over a pending row, so ready drops in that cycle.
  assign s_ready   = (state_q == LOAD) && !abort;
  assign handshake = s_valid && s_ready;

  // Next-state, row counter and write-port computation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    tflag_d     = tflag_q;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_data_d   = rf_data_q;
    err_short_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          row_cnt_d = '0;
          tflag_d   = start_transpose;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d   = IDLE;
          row_cnt_d = '0;
        end else if (handshake) begin
          rf_we_d   = 1'b1;
          rf_addr_d = row_cnt_q;
          rf_data_d = s_data;
          if (row_cnt_q == LAST_ROW || s_last) begin
            // Leaving LOAD here is what keeps row_cnt from ever wrapping.
            state_d     = COMMIT;
            row_cnt_d   = '0;
            err_short_d = (row_cnt_q != LAST_ROW);
          end else begin
            row_cnt_d = row_cnt_q + AW'(1);
          end
        end
      end
      COMMIT: begin
        // The final row's write is on the port during this cycle.
        state_d = abort ? IDLE : FULL;
      end
      FULL: begin
        if (abort || tile_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and write-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    if (RESET) begin
      state_q     <= IDLE;
      row_cnt_q   <= '0;
      tflag_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      // NOTE: the wide data register is reset on purpose; the register file
      // input must read as zero out of reset, not as leftover row data.
      rf_data_q   <= '0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      tflag_q     <= tflag_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_data_q   <= rf_data_d;
      err_short_q <= err_short_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_addr      = rf_addr_q;
  assign rf_dataIn    = rf_data_q;
  assign err_short    = err_short_q;
  assign tile_valid   = (state_q == FULL);
  assign rf_transpose = (state_q == FULL) && tflag_q;
  assign busy         = (state_q != IDLE);

`ifdef REGFILE_CTRL_PERF_EN
  logic [15:0] tile_cnt_q, tile_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Tile counter wraps; stall counter saturates at all-ones.
  always_comb begin
    tile_cnt_d  = tile_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == FULL && tile_ack) begin
      tile_cnt_d = tile_cnt_q + 16'd1;
    end
    if (state_q == LOAD && !s_valid && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Performance counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      tile_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      tile_cnt_q  <= tile_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign tile_cnt  = tile_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
